// File: rtl/uart_tx_cfg.sv
//------------------------------------------------------------------------------
// uart_tx_cfg
//
// Configurable UART transmit serialiser. It takes a parallel word from the
// controller's I/O register logic and shifts it out on the TXD pad. The frame
// is a start bit, DATA_BITS data bits sent LSB first, an optional odd or even
// parity bit, and 1 or 2 stop bits. The frame format is fixed at elaboration.
// Callers use the Start/EOT handshake of the older fixed 8N1 serialiser.
//
// Parameters:
//   FREQ_CLK   system clock frequency in Hz
//   TX_SPEED   baud rate in bit/s; each bit lasts FREQ_CLK/TX_SPEED clocks
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  stop bits per frame (1..2)
//
// Ports:
//   Clk    system clock, rising edge
//   Rst    synchronous reset, active-high; aborts any frame in flight
//   Data   frame payload, captured when Start is accepted
//   Start  transmit request, level-sampled while idle
//   Break  (only with UART_TX_BREAK_EN) holds the line in a break condition
//   EOT    high while idle and ready, low while a frame is in flight
//   TXD    serial line, idle high
//
// Optional feature macro: UART_TX_BREAK_EN adds the Break input and the
// BRK/MARK states. When the macro is undefined, those states and the port
// are absent.
//------------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int unsigned FREQ_CLK  = 100000000,
    parameter int unsigned TX_SPEED  = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Data,
    input  logic                 Start,
`ifdef UART_TX_BREAK_EN
    input  logic                 Break,
`endif
    output logic                 EOT,
    output logic                 TXD
);

    localparam int unsigned DIV   = FREQ_CLK / TX_SPEED;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 1);

    // Reject frame formats that the serialiser cannot produce
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_cfg: FREQ_CLK/TX_SPEED must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
`ifdef UART_TX_BREAK_EN
        ,
        S_BRK,
        S_MARK
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // State and datapath registers; reset returns to an idle, high line
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // Next-state logic. The baud counter runs in every timed state and wraps
    // on the last cycle of each bit. bit_q counts data bits in DATA and stop
    // bits in STOP, so one counter serves both states.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        if (state_q != S_IDLE
`ifdef UART_TX_BREAK_EN
            && state_q != S_BRK
`endif
           ) begin
            baud_d = baud_end ? '0 : baud_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (Break) begin
                    state_d = S_BRK;
                end else
`endif
                if (Start) begin
                    state_d = S_START;
                    shift_d = Data;
                    par_d   = ODD_PAR ? ~^Data : ^Data;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (baud_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BRK: begin
                if (!Break) begin
                    state_d = S_MARK;
                    baud_d  = '0;
                end
            end
            S_MARK: begin
                if (baud_end) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line and handshake decode. The outputs are taken directly from the
    // state, so they change on the edge that enters the state.
    always_comb begin
        TXD = 1'b1;
        EOT = 1'b0;
        case (state_q)
            S_IDLE:  EOT = 1'b1;
            S_START: TXD = 1'b0;
            S_DATA:  TXD = shift_q[0];
            S_PAR:   TXD = par_q;
            S_STOP:  TXD = 1'b1;
`ifdef UART_TX_BREAK_EN
            S_BRK:   TXD = 1'b0;
            S_MARK:  TXD = 1'b1;
`endif
            default: EOT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
//------------------------------------------------------------------------------
// tb_uart_tx_cfg
//
// Drives four differently configured serialisers side by side:
//   0: 8N1, 10 clocks/bit     1: 7E2, 10 clocks/bit
//   2: 9O1, 10 clocks/bit     3: 8N1, 868 clocks/bit (115200 @ 100 MHz)
// The expected line level for every cycle of a frame comes from a small
// frame model. The model works out which bit slot a cycle falls in and what
// that bit should be.
//------------------------------------------------------------------------------
module tb_uart_tx_cfg;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] start;
    logic [3:0] txd;
    logic [3:0] eot;
    logic [8:0] dataIn [4];
`ifdef UART_TX_BREAK_EN
    logic [3:0] brk;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // 100 MHz clock
    always #5 clock = ~clock;

    uart_tx_cfg #(.FREQ_CLK(100000000), .TX_SPEED(10000000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) dut0 (
        .Clk(clock), .Rst(reset), .Data(dataIn[0][7:0]), .Start(start[0]),
`ifdef UART_TX_BREAK_EN
        .Break(brk[0]),
`endif
        .EOT(eot[0]), .TXD(txd[0]));

    uart_tx_cfg #(.FREQ_CLK(100000000), .TX_SPEED(10000000), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2)) dut1 (
        .Clk(clock), .Rst(reset), .Data(dataIn[1][6:0]), .Start(start[1]),
`ifdef UART_TX_BREAK_EN
        .Break(brk[1]),
`endif
        .EOT(eot[1]), .TXD(txd[1]));

    uart_tx_cfg #(.FREQ_CLK(100000000), .TX_SPEED(10000000), .DATA_BITS(9),
                  .PARITY(1), .STOP_BITS(1)) dut2 (
        .Clk(clock), .Rst(reset), .Data(dataIn[2]), .Start(start[2]),
`ifdef UART_TX_BREAK_EN
        .Break(brk[2]),
`endif
        .EOT(eot[2]), .TXD(txd[2]));

    uart_tx_cfg #(.FREQ_CLK(100000000), .TX_SPEED(115200), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) dut3 (
        .Clk(clock), .Rst(reset), .Data(dataIn[3][7:0]), .Start(start[3]),
`ifdef UART_TX_BREAK_EN
        .Break(brk[3]),
`endif
        .EOT(eot[3]), .TXD(txd[3]));

    // Per-instance frame format
    function automatic int divOf(input int i);
        return (i == 3) ? 868 : 10;
    endfunction

    function automatic int dataBitsOf(input int i);
        case (i)
            1:       return 7;
            2:       return 9;
            default: return 8;
        endcase
    endfunction

    function automatic int parityOf(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stopBitsOf(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int frameLen(input int i);
        return divOf(i) * (1 + dataBitsOf(i) + ((parityOf(i) != 0) ? 1 : 0) + stopBitsOf(i));
    endfunction

    // Expected line level c cycles after the Start acceptance edge
    function automatic logic expBit(input int i, input logic [8:0] d, input int c);
        int slot;
        int ones;
        slot = c / divOf(i);
        ones = 0;
        if (slot == 0) return 1'b0;
        if (slot <= dataBitsOf(i)) return d[slot-1];
        if (parityOf(i) != 0 && slot == dataBitsOf(i) + 1) begin
            for (int k = 0; k < dataBitsOf(i); k++) ones += int'(d[k]);
            if (parityOf(i) == 2) return (ones % 2) == 1;
            return (ones % 2) == 0;
        end
        return 1'b1;
    endfunction

    // Count one comparison and report it when the value is wrong
    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            if (errorCount <= 20)
                $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Check that instance i is idle with the line high
    task automatic checkIdle(input int i, input string tag);
        checkOutput($sformatf("%s eot%0d", tag, i), eot[i], 1'b1);
        checkOutput($sformatf("%s txd%0d", tag, i), txd[i], 1'b1);
    endtask

    // Send one frame on instance i and check every cycle of it. At cycle 35
    // a one-cycle Start with different data is injected; it must be ignored.
    // Call at a negedge with the instance idle; the task returns at the
    // negedge just after EOT rises.
    task automatic applyStimulus(input int i, input logic [8:0] d);
        int len;
        len = frameLen(i);
        dataIn[i] = d;
        start[i]  = 1'b1;
        @(negedge clock);
        start[i]  = 1'b0;
        dataIn[i] = 9'($urandom);
        for (int c = 0; c < len; c++) begin
            checkOutput($sformatf("frame%0d txd c%0d", i, c), txd[i], expBit(i, d, c));
            checkOutput($sformatf("frame%0d eot c%0d", i, c), eot[i], 1'b0);
            if (c == 35) begin
                start[i]  = 1'b1;
                dataIn[i] = ~d;
            end
            if (c == 36) start[i] = 1'b0;
            @(negedge clock);
        end
        checkIdle(i, "frame end");
    endtask

    // Hold Start high across two frames: exactly one idle cycle between them
    task automatic backToBack(input int i, input logic [8:0] d1, input logic [8:0] d2);
        int len;
        len = frameLen(i);
        dataIn[i] = d1;
        start[i]  = 1'b1;
        @(negedge clock);
        dataIn[i] = d2;
        for (int c = 0; c < len; c++) begin
            checkOutput($sformatf("b2b%0d first txd c%0d", i, c), txd[i], expBit(i, d1, c));
            checkOutput($sformatf("b2b%0d first eot c%0d", i, c), eot[i], 1'b0);
            @(negedge clock);
        end
        checkIdle(i, "b2b gap");
        @(negedge clock);
        start[i] = 1'b0;
        for (int c = 0; c < len; c++) begin
            checkOutput($sformatf("b2b%0d second txd c%0d", i, c), txd[i], expBit(i, d2, c));
            checkOutput($sformatf("b2b%0d second eot c%0d", i, c), eot[i], 1'b0);
            @(negedge clock);
        end
        checkIdle(i, "b2b end");
    endtask

    // Guard against a hang anywhere in the sequence below
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected the sequence to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        logic [8:0] abortData [3];

        reset = 1'b1;
        start = 4'hF;
        for (int i = 0; i < 4; i++) dataIn[i] = 9'h1FF;
`ifdef UART_TX_BREAK_EN
        brk = 4'h0;
`endif

        // Reset held with Start asserted: no frame may begin
        repeat (10) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) checkIdle(i, "in reset");
        end
        reset = 1'b0;
        start = 4'h0;
        @(negedge clock);
        for (int i = 0; i < 4; i++) checkIdle(i, "after reset");

        // Directed frames, then random frames, with the slow 8N1 instance in parallel
        fork
            applyStimulus(3, 9'h0AA);
            begin
                applyStimulus(0, 9'h0AA);
                applyStimulus(1, 9'h003);
                applyStimulus(2, 9'h003);
                repeat (15) begin
                    fork
                        applyStimulus(0, 9'($urandom));
                        applyStimulus(1, 9'($urandom));
                        applyStimulus(2, 9'($urandom));
                    join
                    repeat ($urandom_range(2, 0)) @(negedge clock);
                end
            end
        join

        // Start held across frame boundaries
        fork
            backToBack(0, 9'h0CC, 9'h055);
            backToBack(1, 9'($urandom), 9'($urandom));
        join

        // Reset pulse in the middle of a frame
        for (int i = 0; i < 3; i++) begin
            abortData[i] = 9'($urandom);
            dataIn[i]    = abortData[i];
        end
        start[2:0] = 3'b111;
        @(negedge clock);
        start[2:0] = 3'b000;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("pre-abort%0d txd c%0d", i, c), txd[i], expBit(i, abortData[i], c));
            if (c == 39) reset = 1'b1;
            @(negedge clock);
        end
        for (int i = 0; i < 3; i++) checkIdle(i, "abort");
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) checkIdle(i, "after abort");
        fork
            applyStimulus(0, 9'($urandom));
            applyStimulus(1, 9'($urandom));
            applyStimulus(2, 9'($urandom));
        join

`ifdef UART_TX_BREAK_EN
        // Break for 50 cycles (Start ignored), then a one-bit mark, then idle
        brk[0]    = 1'b1;
        start[0]  = 1'b1;
        dataIn[0] = 9'h0F0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            checkOutput($sformatf("break txd c%0d", c), txd[0], 1'b0);
            checkOutput($sformatf("break eot c%0d", c), eot[0], 1'b0);
            if (c == 9) start[0] = 1'b0;
        end
        brk[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput($sformatf("mark txd c%0d", c), txd[0], 1'b1);
            checkOutput($sformatf("mark eot c%0d", c), eot[0], 1'b0);
        end
        @(negedge clock);
        checkIdle(0, "after mark");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
